// File: rtl/spm_control_if.sv
// Bundle for the simple-processor controller: IR/zero-flag inputs and datapath strobes.
// Latency: none; pure signal bundle. Backpressure: none; control strobes are fire-and-forget.
// Ports: instr, zero (to controller); load_r0..3, load_pc, inc_pc, load_ir, load_add_r,
//        load_reg_y, load_reg_z, sel_bus_1, sel_bus_2, write, halt, state (from controller).
interface spm_control_if;
   logic [7:0] instr;
   logic       zero;
   logic       load_r0;
   logic       load_r1;
   logic       load_r2;
   logic       load_r3;
   logic       load_pc;
   logic       inc_pc;
   logic       load_ir;
   logic       load_add_r;
   logic       load_reg_y;
   logic       load_reg_z;
   logic [2:0] sel_bus_1;
   logic [1:0] sel_bus_2;
   logic       write;
   logic       halt;
   logic [3:0] state;

   // master drives the IR/flag side, slave is the controller
   modport master (
      output instr, zero,
      input  load_r0, load_r1, load_r2, load_r3, load_pc, inc_pc, load_ir,
             load_add_r, load_reg_y, load_reg_z, sel_bus_1, sel_bus_2,
             write, halt, state
   );
   modport slave (
      input  instr, zero,
      output load_r0, load_r1, load_r2, load_r3, load_pc, inc_pc, load_ir,
             load_add_r, load_reg_y, load_reg_z, sel_bus_1, sel_bus_2,
             write, halt, state
   );
endinterface

// File: rtl/spm_control.sv
// Instruction-sequencing FSM for the simple processor: fetch, decode, execute strobes.
// Latency: outputs are combinational from state/instr/zero; 3 to 5 clocks per instruction.
// Backpressure: none; the datapath is assumed to accept every strobe in the cycle issued.
// Ports: clk, rst_n (sync, active low); bus (slave) carries instr/zero in, strobes/selects out.
module spm_control (
   input  logic          clk,
   input  logic          rst_n,
   spm_control_if.slave  bus
);
   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_FET1 = 4'd1, S_FET2 = 4'd2, S_DEC = 4'd3,
      S_EX1  = 4'd4, S_RD1  = 4'd5, S_RD2  = 4'd6, S_WR1 = 4'd7,
      S_WR2  = 4'd8, S_BR1  = 4'd9, S_BR2  = 4'd10, S_HALT = 4'd11
   } state_t;

   localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                          OP_NOT = 4'd4, OP_RD  = 4'd5, OP_WR  = 4'd6, OP_BR  = 4'd7,
                          OP_BRZ = 4'd8;

   // Plain vector so unused encodings 12..15 are representable and recoverable.
   logic [3:0] r_state;
   state_t     w_next;

   logic [3:0] w_op;
   logic [1:0] w_src;
   logic [1:0] w_dst;
   logic [3:0] w_ld_r;
   logic       w_ld_pc, w_inc_pc, w_ld_ir, w_ld_add, w_ld_y, w_ld_z;
   logic [2:0] w_sel1;
   logic [1:0] w_sel2;
   logic       w_write, w_halt;

   assign w_op  = bus.instr[7:4];
   assign w_src = bus.instr[3:2];
   assign w_dst = bus.instr[1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = S_HALT;
      w_ld_r   = 4'b0000;
      w_ld_pc  = 1'b0;
      w_inc_pc = 1'b0;
      w_ld_ir  = 1'b0;
      w_ld_add = 1'b0;
      w_ld_y   = 1'b0;
      w_ld_z   = 1'b0;
      w_sel1   = 3'd0;
      w_sel2   = 2'd0;
      w_write  = 1'b0;
      w_halt   = 1'b0;
      case (r_state)
         S_IDLE: w_next = S_FET1;
         S_FET1: begin
            w_sel1   = 3'd4;
            w_sel2   = 2'd1;
            w_ld_add = 1'b1;
            w_next   = S_FET2;
         end
         S_FET2: begin
            w_sel2   = 2'd2;
            w_ld_ir  = 1'b1;
            w_inc_pc = 1'b1;
            w_next   = S_DEC;
         end
         S_DEC: begin
            case (w_op)
               OP_NOP: w_next = S_FET1;
               OP_ADD, OP_SUB, OP_AND: begin
                  w_sel1 = {1'b0, w_src};
                  w_sel2 = 2'd1;
                  w_ld_y = 1'b1;
                  w_next = S_EX1;
               end
               OP_NOT: begin
                  w_sel1        = {1'b0, w_src};
                  w_ld_z        = 1'b1;
                  w_ld_r[w_dst] = 1'b1;
                  w_next        = S_FET1;
               end
               OP_RD, OP_WR: begin
                  w_sel1   = 3'd4;
                  w_sel2   = 2'd1;
                  w_ld_add = 1'b1;
                  w_next   = (w_op == OP_RD) ? S_RD1 : S_WR1;
               end
               OP_BR, OP_BRZ: begin
                  // Untaken BRZ only steps the PC past the branch-target byte.
                  if (w_op == OP_BR || bus.zero) begin
                     w_sel1   = 3'd4;
                     w_sel2   = 2'd1;
                     w_ld_add = 1'b1;
                     w_next   = S_BR1;
                  end else begin
                     w_inc_pc = 1'b1;
                     w_next   = S_FET1;
                  end
               end
               default: w_next = S_HALT;
            endcase
         end
         S_EX1: begin
            w_sel1        = {1'b0, w_dst};
            w_ld_z        = 1'b1;
            w_ld_r[w_dst] = 1'b1;
            w_next        = S_FET1;
         end
         S_RD1, S_WR1: begin
            w_sel2   = 2'd2;
            w_ld_add = 1'b1;
            w_inc_pc = 1'b1;
            w_next   = (r_state == S_RD1) ? S_RD2 : S_WR2;
         end
         S_RD2: begin
            w_sel2        = 2'd2;
            w_ld_r[w_dst] = 1'b1;
            w_next        = S_FET1;
         end
         S_WR2: begin
            w_sel1  = {1'b0, w_src};
            w_write = 1'b1;
            w_next  = S_FET1;
         end
         S_BR1: begin
            w_sel2   = 2'd2;
            w_ld_add = 1'b1;
            w_next   = S_BR2;
         end
         S_BR2: begin
            w_sel2  = 2'd2;
            w_ld_pc = 1'b1;
            w_next  = S_FET1;
         end
         S_HALT: begin
            w_halt = 1'b1;
            w_next = S_HALT;
         end
         default: w_next = S_HALT;
      endcase
   end

   assign bus.load_r0    = w_ld_r[0];
   assign bus.load_r1    = w_ld_r[1];
   assign bus.load_r2    = w_ld_r[2];
   assign bus.load_r3    = w_ld_r[3];
   assign bus.load_pc    = w_ld_pc;
   assign bus.inc_pc     = w_inc_pc;
   assign bus.load_ir    = w_ld_ir;
   assign bus.load_add_r = w_ld_add;
   assign bus.load_reg_y = w_ld_y;
   assign bus.load_reg_z = w_ld_z;
   assign bus.sel_bus_1  = w_sel1;
   assign bus.sel_bus_2  = w_sel2;
   assign bus.write      = w_write;
   assign bus.halt       = w_halt;
   assign bus.state      = r_state;
endmodule

// File: tb/tb_spm_control.sv
// Randomised scoreboard bench for spm_control: per-instruction cycle expectations vs DUT.
// Latency: expectations are queued per cycle and checked 2 time units after each falling edge.
// Backpressure: none; every queued expectation is consumed by the monitor.
module tb_spm_control;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spm_control_if bus ();
   spm_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] ldr;
      logic       ld_pc, inc_pc, ld_ir, ld_add, ld_y, ld_z;
      logic [2:0] s1;
      logic [1:0] s2;
      logic       wr, hlt;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    errors = 0;
   int    checks = 0;

   function automatic exp_t base(input logic [3:0] st);
      exp_t e;
      e = '0;
      e.st = st;
      return e;
   endfunction

   function automatic logic rz();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock of stimulus: drive inputs after the falling edge, queue what must be seen.
   task automatic step(input exp_t e, input string nm, input logic [7:0] ins,
                       input logic z, input logic rst = 1'b1);
      @(negedge clk);
      rst_n     = rst;
      bus.instr = ins;
      bus.zero  = z;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic fetch(input logic [7:0] ins);
      exp_t e;
      e = base(4'd1); e.s1 = 3'd4; e.s2 = 2'd1; e.ld_add = 1'b1;
      step(e, "fet1", ins, rz());
      e = base(4'd2); e.s2 = 2'd2; e.ld_ir = 1'b1; e.inc_pc = 1'b1;
      step(e, "fet2", ins, rz());
   endtask

   // Whole-instruction model: the cycle-by-cycle strobe pattern each opcode must produce.
   task automatic run_instr(input logic [7:0] ins, input logic z);
      exp_t e;
      logic [3:0] op;
      logic [1:0] src, dst;
      op = ins[7:4]; src = ins[3:2]; dst = ins[1:0];
      fetch(ins);
      e = base(4'd3);
      if (op >= 4'd1 && op <= 4'd3) begin
         e.s1 = {1'b0, src}; e.s2 = 2'd1; e.ld_y = 1'b1;
         step(e, "dec_alu", ins, z);
         e = base(4'd4); e.s1 = {1'b0, dst}; e.ld_z = 1'b1; e.ldr[dst] = 1'b1;
         step(e, "ex1", ins, rz());
      end else if (op == 4'd4) begin
         e.s1 = {1'b0, src}; e.ld_z = 1'b1; e.ldr[dst] = 1'b1;
         step(e, "dec_not", ins, z);
      end else if ((op >= 4'd5 && op <= 4'd7) || (op == 4'd8 && z)) begin
         e.s1 = 3'd4; e.s2 = 2'd1; e.ld_add = 1'b1;
         step(e, "dec_mem", ins, z);
         if (op == 4'd5 || op == 4'd6) begin
            e = base(op == 4'd5 ? 4'd5 : 4'd7); e.s2 = 2'd2; e.ld_add = 1'b1; e.inc_pc = 1'b1;
            step(e, "rw1", ins, rz());
            if (op == 4'd5) begin
               e = base(4'd6); e.s2 = 2'd2; e.ldr[dst] = 1'b1;
               step(e, "rd2", ins, rz());
            end else begin
               e = base(4'd8); e.s1 = {1'b0, src}; e.wr = 1'b1;
               step(e, "wr2", ins, rz());
            end
         end else begin
            e = base(4'd9); e.s2 = 2'd2; e.ld_add = 1'b1;
            step(e, "br1", ins, rz());
            e = base(4'd10); e.s2 = 2'd2; e.ld_pc = 1'b1;
            step(e, "br2", ins, rz());
         end
      end else if (op == 4'd8) begin
         e.inc_pc = 1'b1;
         step(e, "dec_brz_nt", ins, z);
      end else begin
         step(e, "dec_nop", ins, z);
      end
   endtask

   // Monitor: compare every queued expectation against the live outputs.
   initial begin
      exp_t  a, e;
      string nm;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a.st = bus.state;
            a.ldr = {bus.load_r3, bus.load_r2, bus.load_r1, bus.load_r0};
            a.ld_pc = bus.load_pc;      a.inc_pc = bus.inc_pc;
            a.ld_ir = bus.load_ir;      a.ld_add = bus.load_add_r;
            a.ld_y = bus.load_reg_y;    a.ld_z = bus.load_reg_z;
            a.s1 = bus.sel_bus_1;       a.s2 = bus.sel_bus_2;
            a.wr = bus.write;           a.hlt = bus.halt;
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL %s: got state=%0d vec=%h, required state=%0d vec=%h",
                        nm, a.st, a, e.st, e);
            end
         end
      end
   end

   initial begin
      exp_t e;
      bus.instr = 8'h00;
      bus.zero  = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      step(base(4'd0), "reset_idle", 8'h00, 1'b0, 1'b0);
      step(base(4'd0), "reset_release", 8'h00, 1'b1, 1'b1);

      run_instr(8'h16, rz());
      run_instr(8'h80, 1'b0);
      run_instr(8'h80, 1'b1);
      run_instr(8'h6C, rz());
      run_instr(8'h00, rz());

      for (int i = 0; i < 40; i++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 8));
         run_instr({op, 4'($urandom)}, rz());
      end

      // Illegal opcode: decode, then locked in HALT whatever instr/zero do.
      fetch(8'hF0);
      step(base(4'd3), "dec_illegal", 8'hF0, rz());
      e = base(4'd11); e.hlt = 1'b1;
      for (int i = 0; i < 20; i++) step(e, "halt_hold", 8'($urandom), rz());
      step(e, "halt_rst", 8'($urandom), rz(), 1'b0);
      step(base(4'd0), "halt_rst_idle", 8'h00, rz(), 1'b1);

      // Reset landing in RD1 abandons the read.
      fetch(8'h59);
      e = base(4'd3); e.s1 = 3'd4; e.s2 = 2'd1; e.ld_add = 1'b1;
      step(e, "dec_rd", 8'h59, rz());
      e = base(4'd5); e.s2 = 2'd2; e.ld_add = 1'b1; e.inc_pc = 1'b1;
      step(e, "rd1_rst", 8'h59, rz(), 1'b0);
      step(base(4'd0), "mid_rst_idle", 8'h59, rz(), 1'b1);
      run_instr(8'h2E, rz());

      // Unused encoding 13 must fall into HALT after one clock.
      @(negedge clk);
      force dut.r_state = 4'd13;
      bus.instr = 8'h11;
      bus.zero  = rz();
      exp_q.push_back(base(4'd13));
      name_q.push_back("illegal_state");
      #3;
      release dut.r_state;
      e = base(4'd11); e.hlt = 1'b1;
      step(e, "illegal_to_halt", 8'h11, rz());
      step(e, "illegal_halt_hold", 8'h00, rz());

      repeat (2) @(negedge clk);
      #4;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
